edge_event_arbiter: RTL and testbench
=====================================

# edge_event_arbiter

Sequences falling-edge events on a 32-bit input bus out to a single consumer. Falling edges are captured into sticky per-bit pending flags. The block picks one pending flag at a time by round-robin and presents its index on a valid/ready port. It clears that flag when the consumer accepts it. It sits between the edge-capture datapath and an interrupt/event consumer, so the consumer services one channel per handshake.

## Interface
Parameters:
- NUM_CH, 32: number of input channels (fixed at 32 for this release).
- IDX_W, 5: index width, $clog2(NUM_CH).

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- data_i  input  NUM_CH  monitored signals.
- mask_i  input  NUM_CH  1 = channel not eligible for arbitration (present only with EDGE_ARB_MASK_EN).
- evt_valid_o  output  1  event index presented.
- evt_idx_o  output  IDX_W  index of the presented channel.
- evt_ready_i  input  1  consumer accepts the event.
- pending_o  output  NUM_CH  current sticky pending flags.

## Operation
- Sampling: data_q <= data_i every cycle. The falling-edge vector is fall = data_q & ~data_i.
- Pending: pending_q[i] is set when fall[i]=1. It is cleared when an event with idx=i is accepted (evt_valid_o & evt_ready_i).
- Simultaneous set and clear on the same bit: set wins, so pending stays 1 and the channel is re-served later.
- Eligible vector: elig = pending_q (& ~mask_i when the mask is enabled).
- Round-robin pointer last_q (IDX_W bits): the search starts at last_q+1, modulo NUM_CH, and wraps.
- FSM states:
  - IDLE: evt_valid_o=0. If elig≠0, latch the winner into idx_q and go to PRESENT. Otherwise stay in IDLE.
  - PRESENT: evt_valid_o=1 and evt_idx_o=idx_q. Both are held stable until evt_ready_i=1.
  - On handshake: clear pending_q[idx_q], set last_q <= idx_q, go to IDLE.
- Once an event is presented, it is never withdrawn. This holds even if mask_i later masks the channel, because the pending bit remains set.
- Edges on a channel that is already pending merge into that single pending bit and are not counted.
- Reset values: data_q=0, pending_q=0, state=IDLE, idx_q=0, last_q=NUM_CH-1 (so channel 0 has first priority).
- Reset output values: evt_valid_o=0, evt_idx_o=0, pending_o=0.
- Reset mid-operation: all state is cleared asynchronously, evt_valid_o drops immediately, and a presented event is lost.

## Timing
- Edge at sample edge T (data_i first sampled low while data_q=1): pending_o bit is high after T. evt_valid_o is high after T+1 if the channel wins arbitration.
- evt_valid_o, evt_idx_o and pending_o are driven from flops. There is no combinational path from evt_ready_i to any output.
- Throughput: one accepted event per 2 cycles at most, with a mandatory IDLE bubble after each handshake.
- Ready may be high before valid. A handshake happens only in a cycle where both are high.
- Fairness: a pending, eligible channel waits at most NUM_CH-1 grants.

## Configuration
- EDGE_ARB_MASK_EN defined: the mask_i port exists and elig = pending_q & ~mask_i. Masked channels still capture edges into pending_o.
- EDGE_ARB_MASK_EN undefined: there is no mask_i port and elig = pending_q.

## Structure
- Package edge_arb_pkg holds:
  - NUM_CH and IDX_W localparams.
  - The FSM state enum, arb_state_t {IDLE, PRESENT}.
- One sub-module, rr_arbiter. It is purely combinational: inputs are the req vector and the last pointer; outputs are grant_valid and grant_idx. It does a rotate, a priority encode, and an un-rotate.
- The top module owns data_q, pending_q, the FSM, idx_q and last_q.

## Test plan
- Single edge: after reset, data_i=32'h1, then data_i=0 at edge T with ready=1. pending_o=32'h1 after T; valid=1, idx=0 after T+1; pending_o=0 after the handshake.
- Round-robin: drop bits 3, 7 and 30 in the same cycle with ready=1. Indices come out 3, 7, 30, each valid pulse separated by one IDLE cycle. Then drop bit 3 again; it is served next.
- Backpressure: present idx=5 with ready=0 for 10 cycles. valid and idx stay 5 throughout; a new edge on bit 2 during the stall does not change idx. After ready, 2 is served next.
- Set/clear collision: bit 9 falls again in the exact handshake cycle of idx=9. pending_o[9] stays 1 and idx 9 is presented again.
- Reset mid-PRESENT: assert reset while valid=1 and idx=12. valid and pending_o go to 0 without waiting for a clock edge; after release, with data_i held at 0 and no new edges, no event appears.
- Mask (EDGE_ARB_MASK_EN): mask_i=32'h10 and bit 4 falls. pending_o[4]=1 and no valid. Clear the mask; idx=4 is presented.

Source files
------------

// File: rtl/edge_event_arbiter_pkg.sv
// Shared constants and FSM state type for the falling-edge event arbiter.
package edge_arb_pkg;

    localparam int unsigned NUM_CH = 32;
    localparam int unsigned IDX_W  = $clog2(NUM_CH);

    typedef enum logic {
        IDLE,
        PRESENT
    } arb_state_t;

endpackage

// File: rtl/edge_event_arbiter_if.sv
// Event handshake between the arbiter (master) and its consumer (slave).
interface edge_event_arbiter_if;
    import edge_arb_pkg::*;

    logic             evt_valid_o;
    logic [IDX_W-1:0] evt_idx_o;
    logic             evt_ready_i;

    modport master (
        output evt_valid_o,
        output evt_idx_o,
        input  evt_ready_i
    );

    modport slave (
        input  evt_valid_o,
        input  evt_idx_o,
        output evt_ready_i
    );

endinterface

// File: rtl/edge_event_arbiter_rr_arbiter.sv
// Combinational round-robin pick: rotate so the search starts at last_i+1,
// priority-encode the lowest set bit, then rotate the offset back to an index.
module rr_arbiter
    import edge_arb_pkg::*;
(
    input  logic [NUM_CH-1:0] req_i,
    input  logic [IDX_W-1:0]  last_i,
    output logic              grant_valid_o,
    output logic [IDX_W-1:0]  grant_idx_o
);

    logic [IDX_W-1:0]  start;
    logic [IDX_W-1:0]  src;
    logic [IDX_W-1:0]  off;
    logic [NUM_CH-1:0] rot;
    logic              found;

    // IDX_W-bit arithmetic wraps modulo NUM_CH for free.
    assign start = last_i + 1'b1;

    always_comb begin
        rot   = '0;
        src   = '0;
        off   = '0;
        found = 1'b0;
        for (int unsigned j = 0; j < NUM_CH; j++) begin
            src    = start + IDX_W'(j);
            rot[j] = req_i[src];
        end
        for (int unsigned j = 0; j < NUM_CH; j++) begin
            if (rot[j] && !found) begin
                found = 1'b1;
                off   = IDX_W'(j);
            end
        end
    end

    assign grant_valid_o = found;
    assign grant_idx_o   = start + off;

endmodule

// File: rtl/edge_event_arbiter.sv
// Captures falling edges into sticky pending flags and serves them one at a time
// by round-robin over a valid/ready port. Optional mask_i under EDGE_ARB_MASK_EN.
module edge_event_arbiter
    import edge_arb_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_CH-1:0]    data_i,
`ifdef EDGE_ARB_MASK_EN
    input  logic [NUM_CH-1:0]    mask_i,
`endif
    output logic [NUM_CH-1:0]    pending_o,
    edge_event_arbiter_if.master evt
);

    logic [NUM_CH-1:0] data_q;
    logic [NUM_CH-1:0] pending_q;
    logic [NUM_CH-1:0] pending_d;
    logic [NUM_CH-1:0] fall;
    logic [NUM_CH-1:0] elig;
    arb_state_t        state_q;
    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W-1:0]  last_q;
    logic              valid_q;
    logic              hs;
    logic              grant_valid;
    logic [IDX_W-1:0]  grant_idx;

    assign fall = data_q & ~data_i;
    assign hs   = (state_q == PRESENT) && evt.evt_ready_i;

`ifdef EDGE_ARB_MASK_EN
    assign elig = pending_q & ~mask_i;
`else
    assign elig = pending_q;
`endif

    // Set is applied after clear so a new edge in the handshake cycle survives.
    always_comb begin
        pending_d = pending_q;
        if (hs) begin
            pending_d[idx_q] = 1'b0;
        end
        pending_d = pending_d | fall;
    end

    rr_arbiter u_rr (
        .req_i         (elig),
        .last_i        (last_q),
        .grant_valid_o (grant_valid),
        .grant_idx_o   (grant_idx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q    <= '0;
            pending_q <= '0;
        end else begin
            data_q    <= data_i;
            pending_q <= pending_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            last_q  <= IDX_W'(NUM_CH - 1);
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_valid) begin
                        idx_q   <= grant_idx;
                        valid_q <= 1'b1;
                        state_q <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (evt.evt_ready_i) begin
                        last_q  <= idx_q;
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign evt.evt_valid_o = valid_q;
    assign evt.evt_idx_o   = idx_q;
    assign pending_o       = pending_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed bench for edge_event_arbiter: a per-cycle vector table plus
// hand-written backpressure, collision, reset and (optional) mask sequences.
module tb_edge_event_arbiter;

    logic        clk;
    logic        reset;
    logic [31:0] data;
    logic [31:0] mask;
    logic [31:0] pend;

    int checks;
    int failures;

    edge_event_arbiter_if bus ();

    edge_event_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .data_i    (data),
`ifdef EDGE_ARB_MASK_EN
        .mask_i    (mask),
`endif
        .pending_o (pend),
        .evt       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        ready;
        logic        exp_valid;
        logic [4:0]  exp_idx;
        logic [31:0] exp_pend;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic [31:0] d, input logic rdy);
        data            = d;
        bus.evt_ready_i = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string name, input logic v, input logic [4:0] i, input logic [31:0] p);
        check({name, ".valid"},   32'(bus.evt_valid_o), 32'(v));
        check({name, ".idx"},     32'(bus.evt_idx_o),   32'(i));
        check({name, ".pending"}, pend,                 p);
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        data            = '0;
        mask            = '0;
        bus.evt_ready_i = 1'b0;
        reset           = 1'b1;

        // Single edge on bit 0
        vecs[0]  = '{32'h0000_0001, 1'b1, 1'b0, 5'd0,  32'h0000_0000};
        vecs[1]  = '{32'h0000_0000, 1'b1, 1'b0, 5'd0,  32'h0000_0001};
        vecs[2]  = '{32'h0000_0000, 1'b1, 1'b1, 5'd0,  32'h0000_0001};
        vecs[3]  = '{32'h0000_0000, 1'b1, 1'b0, 5'd0,  32'h0000_0000};
        vecs[4]  = '{32'h0000_0000, 1'b1, 1'b0, 5'd0,  32'h0000_0000};
        // Round-robin over bits 3, 7, 30, then bit 3 again
        vecs[5]  = '{32'h4000_0088, 1'b1, 1'b0, 5'd0,  32'h0000_0000};
        vecs[6]  = '{32'h0000_0000, 1'b1, 1'b0, 5'd0,  32'h4000_0088};
        vecs[7]  = '{32'h0000_0000, 1'b1, 1'b1, 5'd3,  32'h4000_0088};
        vecs[8]  = '{32'h0000_0000, 1'b1, 1'b0, 5'd3,  32'h4000_0080};
        vecs[9]  = '{32'h0000_0000, 1'b1, 1'b1, 5'd7,  32'h4000_0080};
        vecs[10] = '{32'h0000_0000, 1'b1, 1'b0, 5'd7,  32'h4000_0000};
        vecs[11] = '{32'h0000_0000, 1'b1, 1'b1, 5'd30, 32'h4000_0000};
        vecs[12] = '{32'h0000_0008, 1'b1, 1'b0, 5'd30, 32'h0000_0000};
        vecs[13] = '{32'h0000_0000, 1'b1, 1'b0, 5'd30, 32'h0000_0008};
        vecs[14] = '{32'h0000_0000, 1'b1, 1'b1, 5'd3,  32'h0000_0008};
        vecs[15] = '{32'h0000_0000, 1'b1, 1'b0, 5'd3,  32'h0000_0000};

        repeat (2) @(posedge clk);
        #1;
        check_out("reset", 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) begin
            step(vecs[i].data, vecs[i].ready);
            check_out($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_idx, vecs[i].exp_pend);
        end

        // Backpressure: idx 5 held while bit 2 falls during the stall
        step(32'h24, 1'b0);
        step(32'h04, 1'b0);
        check_out("bp.capture", 1'b0, 5'd3, 32'h20);
        step(32'h04, 1'b0);
        for (int c = 0; c < 10; c++) begin
            step((c >= 3) ? 32'h0 : 32'h04, 1'b0);
            check_out($sformatf("bp.stall%0d", c), 1'b1, 5'd5, (c >= 3) ? 32'h24 : 32'h20);
        end
        step(32'h0, 1'b1);
        check_out("bp.accept", 1'b0, 5'd5, 32'h04);
        step(32'h0, 1'b0);
        check_out("bp.next", 1'b1, 5'd2, 32'h04);
        step(32'h0, 1'b1);
        check_out("bp.drain", 1'b0, 5'd2, 32'h0);

        // Set/clear collision on bit 9
        step(32'h200, 1'b0);
        step(32'h0, 1'b0);
        step(32'h0, 1'b0);
        check_out("col.present", 1'b1, 5'd9, 32'h200);
        step(32'h200, 1'b0);
        step(32'h0, 1'b1);
        check_out("col.hs", 1'b0, 5'd9, 32'h200);
        step(32'h0, 1'b0);
        check_out("col.again", 1'b1, 5'd9, 32'h200);
        step(32'h0, 1'b1);
        check_out("col.drain", 1'b0, 5'd9, 32'h0);

        // Reset while presenting idx 12
        step(32'h1000, 1'b0);
        step(32'h0, 1'b0);
        step(32'h0, 1'b0);
        check_out("rst.present", 1'b1, 5'd12, 32'h1000);
        reset = 1'b1;
        #1;
        check_out("rst.async", 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step(32'h0, 1'b0);
            check_out($sformatf("rst.quiet%0d", c), 1'b0, 5'd0, 32'h0);
        end

`ifdef EDGE_ARB_MASK_EN
        // Masked channel captures but is not presented until unmasked
        mask = 32'h10;
        step(32'h10, 1'b0);
        step(32'h0, 1'b0);
        step(32'h0, 1'b0);
        step(32'h0, 1'b0);
        check_out("mask.held", 1'b0, 5'd0, 32'h10);
        mask = 32'h0;
        step(32'h0, 1'b0);
        check_out("mask.release", 1'b1, 5'd4, 32'h10);
        step(32'h0, 1'b1);
        check_out("mask.drain", 1'b0, 5'd4, 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
